// File: rtl/flick_conditioner.sv
// Button conditioner for the lamp flasher: 2-FF sync, 4-state debounce, press pulse and
// a flick latch held until the flasher's stage moves or a timeout. Option: FLICK_LEVEL_PASS_EN.
module flick_conditioner #(
  parameter int DB_CYCLES   = 16,
  parameter int HOLD_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [2:0] stage,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       flick
);

  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {DB_LOW, DB_RISE, DB_HIGH, DB_FALL} db_state_t;

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync1, btn_s;
  logic          level_d, pulse_d;
  logic [2:0]    stage_q;
  logic          latch_q;
  logic [HW-1:0] hold_q;
  logic          stage_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      btn_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= DB_LOW;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      press_pulse <= pulse_d;
    end
  end

  // cnt is cleared on every state exit, so it can never run past CNT_LAST
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_level;
    pulse_d = 1'b0;
    case (state_q)
      DB_LOW: begin
        if (btn_s) begin
          state_d = DB_RISE;
          cnt_d   = '0;
        end
      end
      DB_RISE: begin
        if (!btn_s) begin
          state_d = DB_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DB_HIGH: begin
        if (!btn_s) begin
          state_d = DB_FALL;
          cnt_d   = '0;
        end
      end
      DB_FALL: begin
        if (btn_s) begin
          state_d = DB_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = DB_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign stage_chg = (stage != stage_q);

  // a fresh press outranks consumption/timeout so a new request is never lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= 3'd0;
      latch_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      stage_q <= stage;
      if (press_pulse) begin
        latch_q <= 1'b1;
        hold_q  <= '0;
      end else if (latch_q) begin
        if (stage_chg || hold_q == HOLD_LAST) begin
          latch_q <= 1'b0;
          hold_q  <= '0;
        end else begin
          hold_q <= hold_q + HW'(1);
        end
      end
    end
  end

`ifdef FLICK_LEVEL_PASS_EN
  assign flick = latch_q | btn_level;
`else
  assign flick = latch_q;
`endif

endmodule

// File: tb/tb_flick_conditioner.sv
// Bench for flick_conditioner: directed scenarios plus random stimulus, all checked each
// cycle against a run-length/timer reference model.
module tb_flick_conditioner;
  localparam int DB   = 16;
  localparam int HOLD = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_raw = 1'b0;
  logic [2:0] stage = 3'd0;
  logic       btn_level, press_pulse, flick;

  int checks = 0;
  int failures = 0;
  int pulses_seen = 0;

  flick_conditioner #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .stage(stage),
    .btn_level(btn_level), .press_pulse(press_pulse), .flick(flick)
  );

  always #5 clk = ~clk;

  // reference: level flips after DB+1 consecutive synced samples that disagree with it
  bit         m_s0, m_s1, m_lvl, m_pulse, m_latch;
  int         m_run, m_hold;
  logic [2:0] m_stq;

  function automatic bit m_flick();
`ifdef FLICK_LEVEL_PASS_EN
    return m_latch | m_lvl;
`else
    return m_latch;
`endif
  endfunction

  task automatic mdl_reset();
    m_s0 = 0; m_s1 = 0; m_lvl = 0; m_pulse = 0; m_latch = 0;
    m_run = 0; m_hold = 0; m_stq = 3'd0;
  endtask

  task automatic step();
    bit np, nl, nlatch;
    int nr, nh;
    @(posedge clk);
    if (rst) begin
      np = 0; nl = m_lvl; nr = 0;
      if (m_s1 != m_lvl) begin
        nr = m_run + 1;
        if (nr == DB + 1) begin
          nl = ~m_lvl; nr = 0; np = nl;
        end
      end
      nlatch = m_latch; nh = m_hold;
      if (m_pulse) begin
        nlatch = 1; nh = 0;
      end else if (m_latch) begin
        if (stage != m_stq || m_hold == HOLD - 1) begin
          nlatch = 0; nh = 0;
        end else nh = m_hold + 1;
      end
      m_stq = stage; m_s1 = m_s0; m_s0 = btn_raw;
      m_lvl = nl; m_run = nr; m_pulse = np; m_latch = nlatch; m_hold = nh;
    end
    #1;
    if (press_pulse === 1'b1) pulses_seen++;
    checks += 3;
    if (btn_level !== m_lvl) begin
      failures++; $display("FAIL model_btn_level t=%0t got=%b exp=%b", $time, btn_level, m_lvl);
    end
    if (press_pulse !== m_pulse) begin
      failures++; $display("FAIL model_press_pulse t=%0t got=%b exp=%b", $time, press_pulse, m_pulse);
    end
    if (flick !== m_flick()) begin
      failures++; $display("FAIL model_flick t=%0t got=%b exp=%b", $time, flick, m_flick());
    end
  endtask

  task automatic wait_level(input logic val, input int budget, output int n);
    n = 0;
    do begin step(); n++; end while (btn_level !== val && n < budget);
    if (btn_level !== val) begin
      checks++; failures++;
      $display("FAIL wait_level_timeout got=%b exp=%b after %0d edges", btn_level, val, n);
    end
  endtask

  task automatic count_flick_high(input int budget, output int n);
    n = 0;
    while (flick === 1'b1 && n < budget) begin n++; step(); end
  endtask

  task automatic idle(input int n);
    btn_raw = 1'b0;
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({btn_level, press_pulse, flick} !== 3'b000) begin
      failures++; $display("FAIL reset_outputs got=%b exp=000", {btn_level, press_pulse, flick});
    end
    btn_raw = 1'b0; mdl_reset(); rst = 1'b1;
    repeat (5) step();
  endtask

  task automatic test_clean_press();
    int n, p0;
    idle(90);
    btn_raw = 1'b1;
    wait_level(1'b1, 40, n);
    checks += 2;
    if (n != DB + 3) begin failures++; $display("FAIL clean_latency got=%0d exp=%0d", n, DB + 3); end
    if (press_pulse !== 1'b1) begin failures++; $display("FAIL clean_pulse_on got=%b exp=1", press_pulse); end
    step();
    checks += 2;
    if (press_pulse !== 1'b0) begin failures++; $display("FAIL clean_pulse_off got=%b exp=0", press_pulse); end
    if (flick !== 1'b1) begin failures++; $display("FAIL clean_flick_set got=%b exp=1", flick); end
    repeat (20) step();
    btn_raw = 1'b0; p0 = pulses_seen;
    wait_level(1'b0, 40, n);
    checks += 2;
    if (n != DB + 3) begin failures++; $display("FAIL release_latency got=%0d exp=%0d", n, DB + 3); end
    if (pulses_seen != p0) begin failures++; $display("FAIL release_pulse got=%0d exp=0", pulses_seen - p0); end
  endtask

  task automatic test_bounce();
    int n, p0;
    idle(90);
    p0 = pulses_seen;
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      repeat (5) step();
    end
    checks += 2;
    if (pulses_seen != p0) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulses_seen - p0); end
    if (btn_level !== 1'b0) begin failures++; $display("FAIL bounce_level got=%b exp=0", btn_level); end
    btn_raw = 1'b1;
    wait_level(1'b1, 40, n);
    repeat (3) step();
    checks += 2;
    if (n != DB + 3) begin failures++; $display("FAIL bounce_latency got=%0d exp=%0d", n, DB + 3); end
    if (pulses_seen != p0 + 1) begin failures++; $display("FAIL bounce_one_pulse got=%0d exp=1", pulses_seen - p0); end
  endtask

  task automatic test_consume();
    int n;
    logic exp_f;
    idle(90);
    btn_raw = 1'b1;
    wait_level(1'b1, 40, n);
    repeat (3) step();
    stage = stage + 3'd1;
    step();
`ifdef FLICK_LEVEL_PASS_EN
    exp_f = 1'b1;
`else
    exp_f = 1'b0;
`endif
    checks += 2;
    if (flick !== exp_f) begin failures++; $display("FAIL consume_flick got=%b exp=%b", flick, exp_f); end
    if (btn_level !== 1'b1) begin failures++; $display("FAIL consume_level got=%b exp=1", btn_level); end
  endtask

  task automatic test_timeout();
    int n;
    idle(90);
    stage = 3'd3;
    repeat (2) step();
    btn_raw = 1'b1;
    wait_level(1'b1, 40, n);
    step();
    btn_raw = 1'b0;
    count_flick_high(100, n);
    checks++;
    if (n != HOLD) begin failures++; $display("FAIL timeout_width got=%0d exp=%0d", n, HOLD); end
  endtask

  task automatic test_collision();
    int n, k;
    idle(90);
    stage = 3'd5;
    repeat (2) step();
    btn_raw = 1'b1;
    wait_level(1'b1, 40, n);
    step();
    btn_raw = 1'b0;
    wait_level(1'b0, 40, n);
    btn_raw = 1'b1;
    k = 0;
    while (!m_pulse && k < 40) begin step(); k++; end
    checks++;
    if (!m_pulse || flick !== 1'b1) begin
      failures++; $display("FAIL collision_setup got pulse=%b flick=%b exp pulse=1 flick=1", press_pulse, flick);
    end
    stage = stage + 3'd1;
    step();
    btn_raw = 1'b0;
    checks++;
    if (flick !== 1'b1) begin failures++; $display("FAIL collision_flick got=%b exp=1", flick); end
    count_flick_high(100, n);
    checks++;
    if (n != HOLD) begin failures++; $display("FAIL collision_rehold got=%0d exp=%0d", n, HOLD); end
  endtask

  task automatic test_reset_mid();
    int n, k;
    idle(90);
    btn_raw = 1'b1;
    k = 0;
    while (m_run != 9 && k < 30) begin step(); k++; end
    #2 rst = 1'b0;
    #1 mdl_reset();
    checks++;
    if ({btn_level, press_pulse, flick} !== 3'b000) begin
      failures++; $display("FAIL reset_mid_outputs got=%b exp=000", {btn_level, press_pulse, flick});
    end
    rst = 1'b1;
    wait_level(1'b1, 40, n);
    checks++;
    if (n != DB + 3) begin failures++; $display("FAIL reset_mid_latency got=%0d exp=%0d", n, DB + 3); end
    step();
    #3 rst = 1'b0;
    #1 mdl_reset();
    checks++;
    if ({btn_level, press_pulse, flick} !== 3'b000) begin
      failures++; $display("FAIL reset_hot_outputs got=%b exp=000", {btn_level, press_pulse, flick});
    end
    btn_raw = 1'b0;
    rst = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_random();
    int left;
    left = 0;
    repeat (1500) begin
      if (left == 0) begin
        btn_raw = 1'($urandom);
        left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(10, 45);
      end
      left--;
      if ($urandom_range(0, 11) == 0) stage = 3'($urandom);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mdl_reset();
    #2;
    test_reset();
    test_clean_press();
    test_bounce();
    test_consume();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
